// File: rtl/word_pack_pkg.sv
// rtl/word_pack_pkg.sv - shared types and defaults for the 16-to-32 word packer
package word_pack_pkg;

   localparam int W_IN  = 16;
   localparam int W_OUT = 2 * W_IN;

   localparam logic [W_IN-1:0] PAD_VALUE = '0;

   // EMPTY: no word held; HALF: low word held in lo_q; FULL: beat in output register
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/word_pack_stage.sv
// rtl/word_pack_stage.sv - packs 16-bit words into 32-bit beats (optional WORD_PACK_CSUM_EN)
module word_pack_stage #(
   parameter int                 W_IN      = word_pack_pkg::W_IN,
   parameter logic [W_IN-1:0]    PAD_VALUE = word_pack_pkg::PAD_VALUE,
   parameter int                 CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [W_IN-1:0]       __in0,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic [2*W_IN-1:0]     __out0,
   output logic                  out_valid,
   output logic                  out_pad,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic [CNT_W-1:0]      beat_cnt
`ifdef WORD_PACK_CSUM_EN
   ,
   output logic [W_IN-1:0]       csum
`endif
);

   import word_pack_pkg::*;

   state_t                state_q, state_d;
   logic [W_IN-1:0]       lo_q, lo_d;
   logic [2*W_IN-1:0]     out_q, out_d;
   logic                  pad_q, pad_d;
   logic                  last_q, last_d;
   logic                  in_fire;
   logic                  out_fire;

   // A full output register may still take a word when the sink drains it this cycle
   assign in_ready  = (state_q != FULL) | out_ready;
   assign out_valid = (state_q == FULL);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   assign __out0    = out_q;
   assign out_pad   = pad_q;
   assign out_last  = last_q;

   // Next-state and datapath: FULL with a drained beat behaves like EMPTY for the new word
   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      out_d   = out_q;
      pad_d   = pad_q;
      last_d  = last_q;
      case (state_q)
         EMPTY, FULL: begin
            if (out_fire) begin
               state_d = EMPTY;
            end
            if (in_fire) begin
               if (in_last) begin
                  out_d   = {PAD_VALUE, __in0};
                  pad_d   = 1'b1;
                  last_d  = 1'b1;
                  state_d = FULL;
               end else begin
                  lo_d    = __in0;
                  state_d = HALF;
               end
            end
         end
         HALF: begin
            if (in_fire) begin
               out_d   = {__in0, lo_q};
               pad_d   = 1'b0;
               last_d  = in_last;
               state_d = FULL;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   // State and data registers; a held half-word is simply dropped by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         lo_q    <= '0;
         out_q   <= '0;
         pad_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         out_q   <= out_d;
         pad_q   <= pad_d;
         last_q  <= last_d;
      end
   end

   // Emitted-beat counter, sticks at all-ones instead of wrapping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt <= '0;
      end else if (out_fire && (beat_cnt != {CNT_W{1'b1}})) begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end

`ifdef WORD_PACK_CSUM_EN
   logic [W_IN-1:0] csum_q;

   assign csum = csum_q;

   // Packet XOR: restarts when the closing beat leaves, possibly folding in the next packet's first word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         csum_q <= '0;
      end else begin
         csum_q <= ((out_fire && last_q) ? '0 : csum_q) ^ (in_fire ? __in0 : '0);
      end
   end
`endif

endmodule

// File: tb/tb_word_pack_stage.sv
// tb/tb_word_pack_stage.sv - self-checking bench for word_pack_stage
module tb_word_pack_stage;

   localparam int TB_CNT_W = 4;
   localparam logic [15:0] PAD = 16'h0000;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [15:0]          in_data = '0;
   logic                 in_valid = 1'b0;
   logic                 in_last = 1'b0;
   logic                 in_ready;
   logic [31:0]          out_data;
   logic                 out_valid;
   logic                 out_pad;
   logic                 out_last;
   logic                 out_ready = 1'b0;
   logic [TB_CNT_W-1:0]  beat_cnt;
`ifdef WORD_PACK_CSUM_EN
   logic [15:0]          csum;
`endif

   word_pack_stage #(.W_IN(16), .PAD_VALUE(PAD), .CNT_W(TB_CNT_W)) dut (
      .clk(clk), .rst(rst), .__in0(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .__out0(out_data), .out_valid(out_valid), .out_pad(out_pad),
      .out_last(out_last), .out_ready(out_ready), .beat_cnt(beat_cnt)
`ifdef WORD_PACK_CSUM_EN
      , .csum(csum)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [TB_CNT_W-1:0] exp_cnt = '0;

   typedef struct {
      logic [15:0] w0;
      logic [15:0] w1;
      logic        two;
      logic        l1;
      logic [31:0] exp_d;
      logic        exp_pad;
      logic        exp_last;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic        pad;
      logic        last;
   } beat_t;

   vec_t        vecs[5];
   beat_t       sb[$];
   logic [15:0] pend[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bump_cnt();
      if (exp_cnt != {TB_CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b0;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_pad", {31'd0, out_pad}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_beat_cnt", {28'd0, beat_cnt}, 32'd0);
      exp_cnt = '0;
      sb.delete();
      pend.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   // One random-phase cycle: sample, score, update the word/beat model, advance
   task automatic rand_cycle();
      beat_t b;
      #3;
      chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, (!out_valid) | out_ready});
      chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      chk("rnd_beat_cnt", {28'd0, beat_cnt}, {28'd0, exp_cnt});
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("rnd_unexpected_beat", out_data, 32'hxxxx_xxxx);
         end else begin
            b = sb.pop_front();
            chk("rnd_data", out_data, b.d);
            chk("rnd_pad", {31'd0, out_pad}, {31'd0, b.pad});
            chk("rnd_last", {31'd0, out_last}, {31'd0, b.last});
         end
         bump_cnt();
      end
      if (in_valid && in_ready) begin
         pend.push_back(in_data);
         if (pend.size() == 2) begin
            b.d = {pend[1], pend[0]}; b.pad = 1'b0; b.last = in_last;
            sb.push_back(b);
            pend.delete();
         end else if (in_last) begin
            b.d = {PAD, pend[0]}; b.pad = 1'b1; b.last = 1'b1;
            sb.push_back(b);
            pend.delete();
         end
      end
      tick();
   endtask

   initial begin
      logic [15:0] words[8];
      int nb;

      vecs[0] = '{16'h0001, 16'h0002, 1'b1, 1'b0, 32'h0002_0001, 1'b0, 1'b0};
      vecs[1] = '{16'h00AB, 16'h0000, 1'b0, 1'b0, 32'h0000_00AB, 1'b1, 1'b1};
      vecs[2] = '{16'h1111, 16'h2222, 1'b1, 1'b1, 32'h2222_1111, 1'b0, 1'b1};
      vecs[3] = '{16'hFFFF, 16'h8000, 1'b1, 1'b0, 32'h8000_FFFF, 1'b0, 1'b0};
      vecs[4] = '{16'hBEEF, 16'h0000, 1'b0, 1'b0, 32'h0000_BEEF, 1'b1, 1'b1};

      #12;
      do_reset();
      tick();

      // Table: one beat per record, sink always ready
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         in_valid = 1'b1;
         in_data  = vecs[i].w0;
         in_last  = !vecs[i].two;
         tick();
         if (vecs[i].two) begin
            in_data = vecs[i].w1;
            in_last = vecs[i].l1;
            tick();
         end
         in_valid = 1'b0;
         in_last  = 1'b0;
         #3;
         chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_d);
         chk($sformatf("vec%0d_pad", i), {31'd0, out_pad}, {31'd0, vecs[i].exp_pad});
         chk($sformatf("vec%0d_last", i), {31'd0, out_last}, {31'd0, vecs[i].exp_last});
         tick();
         bump_cnt();
         #3;
         chk($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
         chk($sformatf("vec%0d_cnt", i), {28'd0, beat_cnt}, {28'd0, exp_cnt});
         tick();
      end

      // Back-to-back stream of 8 words: no bubbles on the input side
      for (int i = 0; i < 8; i++) words[i] = 16'h0010 + 16'(i);
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = words[i];
         #3;
         chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
         if (out_valid) begin
            chk("stream_beat", out_data, {words[2*nb+1], words[2*nb]});
            nb++;
            bump_cnt();
         end
         tick();
      end
      in_valid = 1'b0;
      #3;
      chk("stream_tail_valid", {31'd0, out_valid}, 32'd1);
      if (out_valid) begin
         chk("stream_beat", out_data, {words[2*nb+1], words[2*nb]});
         nb++;
         bump_cnt();
      end
      tick();
      chk("stream_nbeats", nb, 32'd4);
      chk("stream_cnt", {28'd0, beat_cnt}, {28'd0, exp_cnt});

      // Backpressure while FULL, then release with a word waiting
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h00A1;
      tick();
      in_data = 16'h00B2;
      tick();
      in_data = 16'h00C3;
      for (int i = 0; i < 5; i++) begin
         #3;
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold", out_data, 32'h00B2_00A1);
         tick();
      end
      out_ready = 1'b1;
      #3;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      tick();
      bump_cnt();
      in_data = 16'h00D4;
      tick();
      in_valid = 1'b0;
      #3;
      chk("bp_next_beat", out_data, 32'h00D4_00C3);
      chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
      tick();
      bump_cnt();
      #3;
      chk("bp_cnt", {28'd0, beat_cnt}, {28'd0, exp_cnt});
      tick();

      // Reset while a half-word is held
      in_valid = 1'b1;
      in_data  = 16'h1234;
      tick();
      in_valid = 1'b0;
      do_reset();
      in_valid = 1'b1;
      in_data  = 16'h0005;
      tick();
      in_data = 16'h0006;
      tick();
      in_valid = 1'b0;
      #3;
      chk("rst_after_data", out_data, 32'h0006_0005);
      chk("rst_after_pad", {31'd0, out_pad}, 32'd0);
      tick();
      bump_cnt();
      #3;
      chk("rst_after_cnt", {28'd0, beat_cnt}, 32'd1);
      tick();

      // Randomized traffic against the packing model; counter saturates along the way
      for (int i = 0; i < 800; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = 16'($urandom);
         in_last   = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 9) < 6);
         rand_cycle();
      end
      for (int i = 0; i < 20; i++) begin
         out_ready = 1'b1;
         in_valid  = (pend.size() != 0);
         in_last   = 1'b1;
         in_data   = 16'($urandom);
         rand_cycle();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("drain_sb_empty", sb.size(), 32'd0);
      chk("drain_pend_empty", pend.size(), 32'd0);
      chk("sat_cnt", {28'd0, beat_cnt}, 32'h0000_000F);

`ifdef WORD_PACK_CSUM_EN
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_last   = 1'b0;
      in_data   = 16'h00F0;
      tick();
      in_data = 16'h000F;
      tick();
      in_data = 16'h0101;
      in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      #3;
      chk("csum_last_beat", {31'd0, out_last}, 32'd1);
      chk("csum_value", {16'd0, csum}, 32'h0000_01FE);
      tick();
      #3;
      chk("csum_cleared", {16'd0, csum}, 32'd0);
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
